// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, optional parity and a small receive FIFO.
// Each entry holds {parity_err, frame_err, data}. A word that completes while the
// FIFO is full, with no pop in that cycle, is dropped and flagged on overrun.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_serial,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_frame_err,
  output logic                          m_parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  typedef struct packed {
    logic                 perr;
    logic                 ferr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  state_t               state, state_nx;
  logic [TW-1:0]        timer, timer_nx;
  logic [IW-1:0]        idx, idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 perr, perr_nx;
  logic                 push, ferr;
  logic                 rx_meta, rx_sync, rx_prev;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
      perr  <= perr_nx;
    end
  end

  // Next-state and sampling decisions; all samples taken from the synchronized line.
  always_comb begin
    state_nx = state;
    timer_nx = timer + 1'b1;
    idx_nx   = idx;
    shreg_nx = shreg;
    perr_nx  = perr;
    push     = 1'b0;
    ferr     = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nx = '0;
        idx_nx   = '0;
        perr_nx  = 1'b0;
        // Edge-triggered so a line stuck low after a framing error cannot retrigger.
        if (rx_prev && !rx_sync) state_nx = S_START;
      end
      S_START: begin
        if (timer == HALF_LAST) begin
          timer_nx = '0;
          state_nx = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer == BIT_LAST) begin
          timer_nx = '0;
          shreg_nx = {rx_sync, shreg[DATA_BITS-1:1]};
          idx_nx   = idx + 1'b1;
          if (idx == IDX_LAST) begin
            idx_nx   = '0;
            state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (timer == BIT_LAST) begin
          timer_nx = '0;
          perr_nx  = ((^shreg) ^ rx_sync) != PAR_ODD;
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (timer == BIT_LAST) begin
          timer_nx = '0;
          push     = 1'b1;
          ferr     = !rx_sync;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en;

  assign full    = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en   = push && (!full || pop);
  assign overrun = push && full && !pop;

  // Storage array; contents only matter where the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{perr: perr, ferr: ferr, data: shreg};
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head outputs read as zero while empty so reset and drained states are clean.
  always_comb begin
    head         = mem[rd_ptr];
    m_data       = m_valid ? head.data : '0;
    m_frame_err  = m_valid && head.ferr;
    m_parity_err = m_valid && head.perr;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance (a) and a 7-bit even-parity instance (b).
// Expected words come from queues filled by the frame senders.
module tb_uart_rx_fifo;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       rdy_a = 1'b0, rdy_rand = 1'b0, rand_on = 1'b0;
  logic       ready_a;
  logic       va, fe_a, pe_a, ovr_a;
  logic [7:0] data_a;
  logic [2:0] cnt_a;
  logic       vb, fe_b, pe_b, ovr_b;
  logic [6:0] data_b;
  logic [2:0] cnt_b;

  assign ready_a = rand_on ? rdy_rand : rdy_a;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_a), .m_valid(va), .m_ready(ready_a),
    .m_data(data_a), .m_frame_err(fe_a), .m_parity_err(pe_a), .overrun(ovr_a),
    .fifo_count(cnt_a));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_b), .m_valid(vb), .m_ready(1'b1),
    .m_data(data_b), .m_frame_err(fe_b), .m_parity_err(pe_b), .overrun(ovr_b),
    .fifo_count(cnt_b));

  int n_chk = 0, n_pass = 0;
  int pops_a = 0, pops_b = 0, ovr_cnt = 0, va_cyc = 0;
  logic [10:0] qa[$], qb[$];
  logic [10:0] ea, eb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v; else rx_a = v;
  endtask

  // Drives start, data LSB first, optional parity and stop; leaves the line at the stop level.
  task automatic send(input bit sel, input logic [8:0] d, input int nb, input bit haspar,
                      input bit pb, input bit stop);
    set_line(sel, 1'b0); tick(CPB);
    for (int i = 0; i < nb; i++) begin set_line(sel, d[i]); tick(CPB); end
    if (haspar) begin set_line(sel, pb); tick(CPB); end
    set_line(sel, stop); tick(CPB);
  endtask

  task automatic frame_a(input logic [7:0] d, input bit stop, input bit drop, input int gap);
    if (!drop) qa.push_back({1'b0, ~stop, 1'b0, d});
    send(1'b0, {1'b0, d}, 8, 1'b0, 1'b0, stop);
    set_line(1'b0, 1'b1); tick(gap);
  endtask

  task automatic frame_b(input logic [6:0] d, input bit pb, input bit stop, input int gap);
    bit perr;
    perr = ((($countones(d) + int'(pb)) % 2) != 0);
    qb.push_back({perr, ~stop, 2'b00, d});
    send(1'b1, {2'b00, d}, 7, 1'b1, pb, stop);
    set_line(1'b1, 1'b1); tick(gap);
  endtask

  // Scoreboard for instance a: every accepted head word must match the model queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (va) va_cyc++;
      if (ovr_a) ovr_cnt++;
      if (va && ready_a) begin
        pops_a++;
        if (qa.size() == 0) chk("a_unexpected_word", {21'd0, pe_a, fe_a, 1'b0, data_a}, 32'hFFFF);
        else begin
          ea = qa.pop_front();
          chk("a_word", {21'd0, pe_a, fe_a, 1'b0, data_a}, {21'd0, ea});
        end
      end
    end
  end

  // Scoreboard for instance b (always ready).
  always @(negedge clk) begin
    if (rst_n) begin
      if (ovr_b) chk("b_overrun", 32'd1, 32'd0);
      if (vb) begin
        pops_b++;
        if (qb.size() == 0) chk("b_unexpected_word", {21'd0, pe_b, fe_b, 2'b00, data_b}, 32'hFFFF);
        else begin
          eb = qb.pop_front();
          chk("b_word", {21'd0, pe_b, fe_b, 2'b00, data_b}, {21'd0, eb});
        end
      end
    end
  end

  // Random ready pattern for the randomized phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      rdy_rand = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int p0;
    // Reset state
    tick(3);
    chk("rst_valid", {31'd0, va}, 32'd0);
    chk("rst_count", {29'd0, cnt_a}, 32'd0);
    chk("rst_data_flags", {22'd0, ovr_a, pe_a, fe_a, data_a}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // 8N1 0xA5 with ready high: one word, valid exactly one cycle
    rdy_a = 1'b1; va_cyc = 0;
    frame_a(8'hA5, 1'b1, 1'b0, 30);
    chk("a5_valid_cycles", va_cyc, 1);
    chk("a5_pops", pops_a, 1);

    // 7E1: 0x35 with parity bit 1 (error) then 0 (good)
    frame_b(7'h35, 1'b1, 1'b1, 20);
    frame_b(7'h35, 1'b0, 1'b1, 30);
    chk("b_pops", pops_b, 2);

    // Framing error, line held low three more bit times
    p0 = pops_a;
    qa.push_back({1'b0, 1'b1, 1'b0, 8'h3C});
    send(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
    tick(3 * CPB);
    chk("ferr_one_word", pops_a - p0, 1);
    chk("ferr_no_restart", {29'd0, cnt_a}, 32'd0);
    set_line(1'b0, 1'b1); tick(20);
    chk("ferr_idle_high", pops_a - p0, 1);
    frame_a(8'hC3, 1'b1, 1'b0, 30);
    chk("ferr_recovery", pops_a - p0, 2);

    // Overflow: five words into a depth-4 FIFO with ready low
    rdy_a = 1'b0; ovr_cnt = 0;
    for (int i = 1; i <= 4; i++) frame_a(8'(i), 1'b1, 1'b0, 5);
    frame_a(8'h05, 1'b1, 1'b1, 10);
    chk("ovf_count", {29'd0, cnt_a}, 32'd4);
    chk("ovf_pulses", ovr_cnt, 1);
    chk("ovf_head_stable", {24'd0, data_a}, 32'h01);
    p0 = pops_a;
    rdy_a = 1'b1; tick(20);
    chk("ovf_drain", pops_a - p0, 4);
    chk("ovf_model_empty", qa.size(), 0);

    // Short low glitch is a false start
    p0 = pops_a;
    set_line(1'b0, 1'b0); tick(4); set_line(1'b0, 1'b1);
    tick(40);
    chk("glitch_count", {29'd0, cnt_a}, 32'd0);
    chk("glitch_pops", pops_a - p0, 0);

    // Reset in the middle of a frame with one word already buffered
    rdy_a = 1'b0;
    frame_a(8'h11, 1'b1, 1'b0, 10);
    chk("pre_rst_count", {29'd0, cnt_a}, 32'd1);
    set_line(1'b0, 1'b0); tick(CPB);
    for (int i = 0; i < 3; i++) begin set_line(1'b0, 1'b1); tick(CPB); end
    rst_n = 1'b0; #1;
    chk("midrst_valid_count", {28'd0, va, cnt_a}, 32'd0);
    chk("midrst_data_flags", {22'd0, ovr_a, pe_a, fe_a, data_a}, 32'd0);
    qa.delete();
    set_line(1'b0, 1'b1); tick(3);
    rst_n = 1'b1; tick(10);
    p0 = pops_a;
    rdy_a = 1'b1;
    frame_a(8'h5A, 1'b1, 1'b0, 30);
    chk("post_rst_word", pops_a - p0, 1);

    // Randomized traffic with random ready on a, random parity/stop bits on b
    ovr_cnt = 0;
    rand_on = 1'b1;
    for (int i = 0; i < 12; i++)
      frame_a(8'($urandom), ($urandom_range(0, 7) != 0), 1'b0, $urandom_range(2, 30));
    for (int i = 0; i < 8; i++)
      frame_b(7'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0),
              $urandom_range(2, 30));
    rand_on = 1'b0;
    tick(30);
    chk("rand_a_drained", qa.size(), 0);
    chk("rand_b_drained", qb.size(), 0);
    chk("rand_no_overrun", ovr_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clk cycles per serial bit, legal range >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries, a power of 2 >= 2.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port rx_serial  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port m_valid  output  1  FIFO head holds a word.
REQ-009 SHALL have port m_ready  input  1  consumer accepts head when m_valid high.
REQ-010 SHALL have port m_data  output  DATA_BITS  head data, LSB = first received bit.
REQ-011 SHALL have port m_frame_err  output  1  head word had stop bit sampled low.
REQ-012 SHALL have port m_parity_err  output  1  head word failed parity check; always 0 when PARITY=0.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently held.

Function
REQ-015 SHALL pass rx_serial through a 2-flop synchronizer; all logic uses the synchronized line only.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP with one bit-timer counter and one bit index.
REQ-017 IDLE: on synchronized falling edge (prev 1, now 0) SHALL clear timer and enter START.
REQ-018 START: at timer = CLKS_PER_BIT/2 - 1 SHALL re-sample; low -> DATA with timer cleared; high -> false start, back to IDLE, nothing pushed.
REQ-019 DATA: SHALL sample at timer = CLKS_PER_BIT - 1 (mid-bit), shift in LSB first, DATA_BITS samples, then PARITY if PARITY != 0 else STOP.
REQ-020 PARITY: SHALL sample one bit mid-bit; parity_err = XOR(data, parity bit) != (PARITY==1 ? 1 : 0).
REQ-021 STOP: SHALL sample mid-bit; frame_err = sampled value is 0; SHALL push {parity_err, frame_err, data} on that same cycle and return to IDLE the next cycle.
REQ-022 Frames with frame_err or parity_err SHALL still be pushed with their flags.
REQ-023 After a frame_err with line held low, IDLE SHALL NOT start a new frame until a 1-to-0 edge is seen.
REQ-024 FIFO: m_valid = (fifo_count != 0); m_data/flags = head entry, held stable while m_valid and !m_ready.
REQ-025 Pop occurs on cycle with m_valid and m_ready; m_ready while empty SHALL be ignored.
REQ-026 Push with FIFO full and no pop the same cycle SHALL drop the word, leave contents unchanged, pulse overrun for one cycle.
REQ-027 Push and pop in the same cycle when full SHALL accept the push; count unchanged, no overrun.
REQ-028 Push and pop in the same cycle when non-full, non-empty SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-029 Latency: word visible on m_valid the cycle after the STOP push cycle.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, timer/index 0, both synchronizer flops to 1, FIFO empty, m_valid 0, fifo_count 0, overrun 0, m_data 0, flags 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; after release, reception resumes on the next falling edge.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-032 8N1 byte 0xA5, m_ready=1 -> m_data=0xA5, both flags 0, m_valid high exactly 1 cycle.
REQ-033 PARITY=2, DATA_BITS=7, frame 0x35 with parity bit 1 -> m_data=0x35, m_parity_err=1; with parity bit 0 -> m_parity_err=0.
REQ-034 0x3C with stop bit 0 -> m_frame_err=1, word pushed; line held low 3 bit times -> no second word until line returns high and falls again.
REQ-035 FIFO_DEPTH=4, m_ready=0, send 5 bytes 0x01..0x05 -> fifo_count=4, one overrun pulse at 5th stop sample; draining yields 0x01..0x04 in order.
REQ-036 Low glitch of 4 cycles on idle line -> false start, fifo_count stays 0; rst_n pulsed low mid-DATA of a byte -> all outputs 0, next full byte 0x5A received correctly.
